// File: rtl/hwt_trigger_seq.sv
// ============================================================================
// hwt_trigger_seq
// Sequential rare-event trojan benchmark: counts consecutive predicate matches
// and opens a timed window in which the registered output is inverted.
// Revision: 1.0
// ============================================================================
`default_nettype none

module hwt_trigger_seq #(
    parameter int TRIG_COUNT     = 4,
    parameter int CNT_W          = 3,
    parameter int PAYLOAD_CYCLES = 8,
    parameter int PAY_W          = 4,
    parameter int FIRE_W         = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              A,
    input  logic              B,
    input  logic              C,
    input  logic              D,
    output logic              Y,
    output logic              armed,
    output logic [CNT_W-1:0]  trig_cnt,
    output logic [FIRE_W-1:0] fire_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_ARMED = 2'd2
    } state_t;

    localparam logic [CNT_W:0]    c_TRIG_TARGET  = (CNT_W+1)'(TRIG_COUNT);
    localparam logic              c_ARM_ON_FIRST = (TRIG_COUNT == 1);
    localparam logic [PAY_W-1:0]  c_PAY_LOAD     = PAY_W'(PAYLOAD_CYCLES - 1);
    localparam logic [FIRE_W-1:0] c_FIRE_MAX     = '1;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    trig_q, trig_d;
    logic [PAY_W-1:0]    pay_q, pay_d;
    logic [FIRE_W-1:0]   fire_q, fire_d;
    logic                y_q, y_d;

    logic                w_cond;
    logic                w_is_armed;
    logic                w_arm_entry;
    logic [CNT_W:0]      w_trig_inc;

    assign w_cond     = D & ((A & B) | C);
    assign w_is_armed = (state_q == ST_ARMED);
    assign w_trig_inc = {1'b0, trig_q} + {{CNT_W{1'b0}}, 1'b1};

    always_comb begin
        state_d     = state_q;
        trig_d      = trig_q;
        pay_d       = pay_q;
        fire_d      = fire_q;
        w_arm_entry = 1'b0;
        y_d         = w_cond ^ w_is_armed;

        case (state_q)
            ST_IDLE: begin
                trig_d = '0;
                if (w_cond) begin
                    if (c_ARM_ON_FIRST) begin
                        w_arm_entry = 1'b1;
                    end else begin
                        state_d = ST_COUNT;
                        trig_d  = {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
            end
            ST_COUNT: begin
                if (!w_cond) begin
                    state_d = ST_IDLE;
                    trig_d  = '0;
                end else if (w_trig_inc == c_TRIG_TARGET) begin
                    w_arm_entry = 1'b1;
                end else begin
                    trig_d = w_trig_inc[CNT_W-1:0];
                end
            end
            ST_ARMED: begin
                // Predicate is deliberately ignored here; only the timer matters.
                trig_d = '0;
                if (pay_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    pay_d = pay_q - PAY_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                trig_d  = '0;
                pay_d   = '0;
            end
        endcase

        if (w_arm_entry) begin
            state_d = ST_ARMED;
            trig_d  = '0;
            pay_d   = c_PAY_LOAD;
            if (fire_q != c_FIRE_MAX) begin
                fire_d = fire_q + FIRE_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            trig_q  <= '0;
            pay_q   <= '0;
            fire_q  <= '0;
            y_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            trig_q  <= trig_d;
            pay_q   <= pay_d;
            fire_q  <= fire_d;
            y_q     <= y_d;
        end
    end

    assign Y        = y_q;
    assign armed    = w_is_armed;
    assign trig_cnt = trig_q;
    assign fire_cnt = fire_q;

endmodule

`default_nettype wire
